lcd_cmd_host: RTL and testbench

- Host-side initiator for the LCD controller command interface.
- Fetches a 4-bit command script from a command memory and issues each command on cmd/cmd_valid, using the controller's busy handshake.
- After issuing WRITE (0), monitors the controller's IRAM write stream until done: counts writes, checks address order, accumulates a checksum.
- Sits between the testbench/system command store and the LCD controller; reports completion and an error code.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_iram_monitor.sv | 70 +++++++
 rtl/lcd_cmd_host.sv | 194 +++++++++++++++++++
 tb/tb_lcd_cmd_host.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD controller and its command host:
// command opcodes, completion codes and image geometry.
package lcd_pkg;

    typedef enum logic [3:0] {
        CMD_WRITE        = 4'd0,
        CMD_SHIFT_UP     = 4'd1,
        CMD_SHIFT_DOWN   = 4'd2,
        CMD_SHIFT_LEFT   = 4'd3,
        CMD_SHIFT_RIGHT  = 4'd4,
        CMD_MAX          = 4'd5,
        CMD_MIN          = 4'd6,
        CMD_AVERAGE      = 4'd7,
        CMD_ROTATE_CCW   = 4'd8,
        CMD_ROTATE_CW    = 4'd9,
        CMD_MIRROR_X     = 4'd10,
        CMD_MIRROR_Y     = 4'd11
    } lcd_opcode_e;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_NO_WRITE = 2'd2;
    localparam logic [1:0] ERR_IRAM     = 2'd3;

    localparam int LCD_IMG_WORDS = 64;
    localparam int LCD_IRAM_AW   = 6;
    localparam int LCD_IRAM_DW   = 8;
    localparam int LCD_SUM_W     = 14;

    // WRITE is the only command that makes the controller stream into IRAM.
    function automatic logic is_write_cmd(input logic [3:0] code);
        return code == CMD_WRITE;
    endfunction

endpackage

// File: rtl/lcd_iram_monitor.sv
// Snoops the controller's IRAM write stream while a WRITE is in progress:
// counts writes, checks that addresses arrive in order and sums the data.
module lcd_iram_monitor
    import lcd_pkg::*;
#(
    parameter int IMG_WORDS = LCD_IMG_WORDS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   IRAM_valid,
    input  logic [LCD_IRAM_AW-1:0] IRAM_A,
    input  logic [LCD_IRAM_DW-1:0] IRAM_D,
    output logic                   count_ok,
    output logic                   iram_err,
    output logic [LCD_SUM_W-1:0]   checksum
);

    // One spare bit plus saturation so an overlong stream never wraps back
    // onto a count that looks correct.
    localparam int CW = $clog2(IMG_WORDS + 1) + 1;

    logic [CW-1:0]          count_reg;
    logic [CW-1:0]          count_next;
    logic [LCD_IRAM_AW-1:0] exp_addr_reg;
    logic                   addr_err_reg;
    logic [LCD_SUM_W-1:0]   checksum_reg;
    logic                   write_hit;
    logic                   addr_mismatch;

    assign write_hit     = enable && IRAM_valid;
    assign addr_mismatch = write_hit && (IRAM_A != exp_addr_reg);

    // Count including a write in the current cycle, so a write that coincides
    // with done is counted before the host judges the total.
    always_comb begin
        count_next = count_reg;
        if (write_hit && (count_reg != '1)) begin
            count_next = count_reg + 1'b1;
        end
    end

    assign count_ok = (count_next == CW'(IMG_WORDS));
    assign iram_err = addr_err_reg || addr_mismatch;
    assign checksum = checksum_reg;

    // Per-run capture state; cleared when the host accepts a new start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg    <= '0;
            exp_addr_reg <= '0;
            addr_err_reg <= 1'b0;
            checksum_reg <= '0;
        end else if (clear) begin
            count_reg    <= '0;
            exp_addr_reg <= '0;
            addr_err_reg <= 1'b0;
            checksum_reg <= '0;
        end else if (write_hit) begin
            count_reg    <= count_next;
            exp_addr_reg <= exp_addr_reg + 1'b1;
            checksum_reg <= checksum_reg + LCD_SUM_W'(IRAM_D);
            if (addr_mismatch) begin
                addr_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_cmd_host.sv
// Host-side initiator for the LCD controller: walks a 4-bit command script,
// issues each command under the busy handshake and, after WRITE, watches the
// IRAM write stream until the controller signals done.
module lcd_cmd_host
    import lcd_pkg::*;
#(
    parameter int AW        = 6,
    parameter int IMG_WORDS = LCD_IMG_WORDS,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   CMD_rd,
    output logic [AW-1:0]          CMD_A,
    input  logic [3:0]             CMD_Q,
    input  logic                   busy,
    output logic [3:0]             cmd,
    output logic                   cmd_valid,
    input  logic                   IRAM_valid,
    input  logic [LCD_IRAM_AW-1:0] IRAM_A,
    input  logic [LCD_IRAM_DW-1:0] IRAM_D,
    input  logic                   done,
    output logic                   host_busy,
    output logic                   finish,
    output logic [1:0]             err_code,
    output logic [AW:0]            cmd_issued,
    output logic [LCD_SUM_W-1:0]   checksum
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_WAIT_RDY = 3'd3;
    localparam logic [2:0] S_SEND     = 3'd4;
    localparam logic [2:0] S_WAIT_ACK = 3'd5;
    localparam logic [2:0] S_CAPTURE  = 3'd6;
    localparam logic [2:0] S_FINISH   = 3'd7;

    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [2:0]    state_reg;
    logic [3:0]    pending_reg;
    logic [TW-1:0] timer_reg;
    logic          CMD_rd_reg;
    logic [AW-1:0] CMD_A_reg;
    logic [3:0]    cmd_reg;
    logic          cmd_valid_reg;
    logic          host_busy_reg;
    logic          finish_reg;
    logic [1:0]    err_code_reg;
    logic [AW:0]   cmd_issued_reg;

    logic          timer_hit;
    logic          start_accept;
    logic          mon_count_ok;
    logic          mon_iram_err;

    // The wait states give up on the cycle that would be the TIMEOUT-th wait.
    assign timer_hit    = (timer_reg == TW'(TIMEOUT - 1));
    assign start_accept = (state_reg == S_IDLE) && start;

    lcd_iram_monitor #(
        .IMG_WORDS (IMG_WORDS)
    ) u_monitor (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_accept),
        .enable     (state_reg == S_CAPTURE),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .count_ok   (mon_count_ok),
        .iram_err   (mon_iram_err),
        .checksum   (checksum)
    );

    // Script sequencer; every output strobe is set on the edge entering the
    // state it belongs to, so outputs come straight from registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            pending_reg    <= '0;
            timer_reg      <= '0;
            CMD_rd_reg     <= 1'b0;
            CMD_A_reg      <= '0;
            cmd_reg        <= '0;
            cmd_valid_reg  <= 1'b0;
            host_busy_reg  <= 1'b0;
            finish_reg     <= 1'b0;
            err_code_reg   <= ERR_OK;
            cmd_issued_reg <= '0;
        end else begin
            CMD_rd_reg    <= 1'b0;
            cmd_valid_reg <= 1'b0;
            finish_reg    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg      <= S_FETCH;
                        CMD_rd_reg     <= 1'b1;
                        CMD_A_reg      <= '0;
                        cmd_issued_reg <= '0;
                        err_code_reg   <= ERR_OK;
                        host_busy_reg  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_reg <= S_LOAD;
                end
                S_LOAD: begin
                    pending_reg <= CMD_Q;
                    timer_reg   <= '0;
                    state_reg   <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (!busy) begin
                        state_reg      <= S_SEND;
                        cmd_reg        <= pending_reg;
                        cmd_valid_reg  <= 1'b1;
                        cmd_issued_reg <= cmd_issued_reg + 1'b1;
                    end else if (timer_hit) begin
                        state_reg     <= S_FINISH;
                        finish_reg    <= 1'b1;
                        host_busy_reg <= 1'b0;
                        err_code_reg  <= ERR_TIMEOUT;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_SEND: begin
                    timer_reg <= '0;
                    if (is_write_cmd(pending_reg)) begin
                        state_reg <= S_CAPTURE;
                    end else if (CMD_A_reg == '1) begin
                        state_reg     <= S_FINISH;
                        finish_reg    <= 1'b1;
                        host_busy_reg <= 1'b0;
                        err_code_reg  <= ERR_NO_WRITE;
                    end else begin
                        CMD_A_reg <= CMD_A_reg + 1'b1;
                        state_reg <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    // Seeing busy high proves the controller took the command,
                    // so the next busy-low window belongs to the next command.
                    if (busy) begin
                        state_reg  <= S_FETCH;
                        CMD_rd_reg <= 1'b1;
                    end else if (timer_hit) begin
                        state_reg     <= S_FINISH;
                        finish_reg    <= 1'b1;
                        host_busy_reg <= 1'b0;
                        err_code_reg  <= ERR_TIMEOUT;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (done) begin
                        state_reg     <= S_FINISH;
                        finish_reg    <= 1'b1;
                        host_busy_reg <= 1'b0;
                        err_code_reg  <= (mon_iram_err || !mon_count_ok) ? ERR_IRAM : ERR_OK;
                    end else if (timer_hit) begin
                        state_reg     <= S_FINISH;
                        finish_reg    <= 1'b1;
                        host_busy_reg <= 1'b0;
                        err_code_reg  <= mon_iram_err ? ERR_IRAM : ERR_TIMEOUT;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                S_FINISH: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign CMD_rd     = CMD_rd_reg;
    assign CMD_A      = CMD_A_reg;
    assign cmd        = cmd_reg;
    assign cmd_valid  = cmd_valid_reg;
    assign host_busy  = host_busy_reg;
    assign finish     = finish_reg;
    assign err_code   = err_code_reg;
    assign cmd_issued = cmd_issued_reg;

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Randomized bench for lcd_cmd_host: a falling-edge command memory and LCD
// controller model drive the DUT, and a script-level reference model predicts
// the issued commands, completion code, command count and checksum.
module tb_lcd_cmd_host;
    import lcd_pkg::*;

    localparam int AW        = 6;
    localparam int IMG       = 64;
    localparam int BM_NORMAL = 0;
    localparam int BM_ZERO   = 1;
    localparam int BM_STUCK  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        CMD_rd;
    logic [5:0]  CMD_A;
    logic [3:0]  CMD_Q = 4'd0;
    logic        busy = 1'b0;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        IRAM_valid = 1'b0;
    logic [5:0]  IRAM_A = 6'd0;
    logic [7:0]  IRAM_D = 8'd0;
    logic        done = 1'b0;
    logic        host_busy;
    logic        finish;
    logic [1:0]  err_code;
    logic [6:0]  cmd_issued;
    logic [13:0] checksum;

    lcd_cmd_host #(.AW(AW), .IMG_WORDS(IMG), .TIMEOUT(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .CMD_rd     (CMD_rd),
        .CMD_A      (CMD_A),
        .CMD_Q      (CMD_Q),
        .busy       (busy),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .done       (done),
        .host_busy  (host_busy),
        .finish     (finish),
        .err_code   (err_code),
        .cmd_issued (cmd_issued),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus configuration
    logic [3:0] script  [64];
    logic [5:0] wr_addr [64];
    logic [7:0] wr_data [64];
    int n_writes;
    int busy_mode;
    int ack_delay;
    bit done_with_last;

    // Observations
    logic [3:0] seen_cmds[$];
    int seen_cyc[$];
    int rd_addrs[$];
    int fin_cnt, fin_cyc, fin_err, fin_issued, fin_sum;

    // Reference model results
    logic [3:0] exp_cmds[$];
    int exp_err, exp_sum;

    int n_vec = 0;
    int n_err = 0;

    // Controller model state
    int wr_idx, gap, ack_cnt;
    bit wr_active;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Script-level prediction: walk the script until WRITE, the last entry,
    // or a command the controller never acknowledges.
    function automatic void model_compute();
        bit bad;
        exp_cmds.delete();
        exp_err = int'(ERR_OK);
        exp_sum = 0;
        for (int i = 0; i < 64; i++) begin
            exp_cmds.push_back(script[i]);
            if (script[i] == 4'd0) begin
                bad = (n_writes != IMG);
                for (int w = 0; w < n_writes; w++) begin
                    exp_sum = (exp_sum + int'(wr_data[w])) % 16384;
                    if (int'(wr_addr[w]) != (w % 64)) bad = 1'b1;
                end
                exp_err = bad ? int'(ERR_IRAM) : int'(ERR_OK);
                return;
            end
            if (busy_mode != BM_NORMAL) begin
                exp_err = int'(ERR_TIMEOUT);
                return;
            end
            if (i == 63) exp_err = int'(ERR_NO_WRITE);
        end
    endfunction

    // Command memory (registered read) and LCD controller model.
    always @(negedge clk) begin
        IRAM_valid = 1'b0;
        done       = 1'b0;
        if (!reset) begin
            wr_active = 1'b0;
            ack_cnt   = 0;
        end else begin
            if (CMD_rd) begin
                CMD_Q = script[CMD_A];
                rd_addrs.push_back(int'(CMD_A));
            end
            if (finish) begin
                fin_cnt++;
                fin_cyc    = cyc;
                fin_err    = int'(err_code);
                fin_issued = int'(cmd_issued);
                fin_sum    = int'(checksum);
            end
            if (cmd_valid) begin
                seen_cmds.push_back(cmd);
                seen_cyc.push_back(cyc);
                if (busy_mode != BM_ZERO) busy = 1'b1;
                if (cmd == 4'd0) begin
                    wr_active = 1'b1;
                    wr_idx    = 0;
                    gap       = int'($urandom_range(0, 3));
                end else begin
                    ack_cnt = ack_delay;
                end
            end else if (wr_active) begin
                if (gap > 0) begin
                    gap--;
                end else if (wr_idx < n_writes) begin
                    IRAM_valid = 1'b1;
                    IRAM_A     = wr_addr[wr_idx];
                    IRAM_D     = wr_data[wr_idx];
                    wr_idx++;
                    gap = int'($urandom_range(0, 1));
                    if (wr_idx == n_writes && done_with_last) begin
                        done      = 1'b1;
                        wr_active = 1'b0;
                        ack_cnt   = ack_delay;
                    end
                end else begin
                    done      = 1'b1;
                    wr_active = 1'b0;
                    ack_cnt   = ack_delay;
                end
            end else if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0 && busy_mode == BM_NORMAL) busy = 1'b0;
            end
        end
    end

    task automatic check_reset_state();
        check_val("rst_CMD_rd",     32'(CMD_rd), 0);
        check_val("rst_CMD_A",      32'(CMD_A), 0);
        check_val("rst_cmd",        32'(cmd), 0);
        check_val("rst_cmd_valid",  32'(cmd_valid), 0);
        check_val("rst_host_busy",  32'(host_busy), 0);
        check_val("rst_finish",     32'(finish), 0);
        check_val("rst_err_code",   32'(err_code), 0);
        check_val("rst_cmd_issued", 32'(cmd_issued), 0);
        check_val("rst_checksum",   32'(checksum), 0);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
        busy           = 1'b0;
        busy_mode      = BM_NORMAL;
        ack_delay      = 3;
        done_with_last = 1'b0;
    endtask

    task automatic good_image(input bit rand_data);
        n_writes = IMG;
        for (int w = 0; w < 64; w++) begin
            wr_addr[w] = 6'(w);
            wr_data[w] = rand_data ? 8'($urandom_range(0, 255)) : 8'(w);
        end
    endtask

    task automatic fill_script(input int lo);
        for (int i = 0; i < 64; i++) script[i] = 4'($urandom_range(lo, 15));
    endtask

    task automatic run_and_check(input string name, input int budget);
        int k;
        model_compute();
        seen_cmds.delete();
        seen_cyc.delete();
        rd_addrs.delete();
        fin_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("host_busy_run", 32'(host_busy), 1);
        k = 0;
        while (fin_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check_val("finish_pulses", fin_cnt, 1);
        check_val("host_busy_end", 32'(host_busy), 0);
        check_val("err_code", fin_err, exp_err);
        check_val("cmd_issued", fin_issued, exp_cmds.size());
        check_val("checksum", fin_sum, exp_sum);
        check_val("err_code_hold", 32'(err_code), exp_err);
        check_val("n_cmds", seen_cmds.size(), exp_cmds.size());
        for (int i = 0; i < seen_cmds.size() && i < exp_cmds.size(); i++)
            check_val("cmd_order", 32'(seen_cmds[i]), 32'(exp_cmds[i]));
        for (int i = 1; i < seen_cyc.size(); i++)
            check_val("issue_gap_ge4", 32'((seen_cyc[i] - seen_cyc[i-1]) >= 4), 1);
        check_val("first_rd_addr", (rd_addrs.size() > 0) ? rd_addrs[0] : -1, 0);
        $display("run %s: cmds=%0d err=%0d/%0d issued=%0d sum=%0d/%0d",
                 name, seen_cmds.size(), fin_err, exp_err, fin_issued, fin_sum, exp_sum);
    endtask

    initial begin
        int k;
        int sel;
        busy_mode      = BM_NORMAL;
        ack_delay      = 3;
        done_with_last = 1'b0;
        fin_cnt        = 0;
        for (int i = 0; i < 64; i++) script[i] = 4'd5;
        good_image(1'b0);

        // Reset values, during and just after reset.
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state();

        // Script {4,7,0}, busy low 3 cycles after each ack, IRAM_D = address.
        settle();
        fill_script(1);
        script[0] = 4'd4; script[1] = 4'd7; script[2] = 4'd0;
        good_image(1'b0);
        run_and_check("basic_470", 6000);
        check_val("sum_2016", fin_sum, 2016);

        // busy held low: command 1 issued once, never acknowledged.
        settle();
        busy_mode = BM_ZERO;
        script[0] = 4'd1; script[1] = 4'd2; script[2] = 4'd0;
        run_and_check("busy_zero", 3000);

        // No WRITE anywhere in the script.
        settle();
        ack_delay = 2;
        fill_script(1);
        run_and_check("no_write", 6000);

        // busy stuck high after the first command.
        settle();
        busy_mode = BM_STUCK;
        fill_script(1);
        run_and_check("busy_stuck", 3000);
        k = (seen_cyc.size() > 0) ? (fin_cyc - seen_cyc[0]) : 0;
        check_val("timeout_window", 32'((k >= 1024) && (k <= 1040)), 1);

        // 63 writes then done.
        settle();
        fill_script(1);
        script[1] = 4'd0;
        good_image(1'b1);
        n_writes = 63;
        run_and_check("short_63", 6000);

        // Address sequence 0,1,3,...
        settle();
        good_image(1'b1);
        wr_addr[2] = 6'd3;
        run_and_check("addr_skip", 6000);

        // Last write coincident with done.
        settle();
        good_image(1'b1);
        done_with_last = 1'b1;
        run_and_check("done_with_64th", 6000);

        // Reset while waiting for busy low on the second command.
        settle();
        ack_delay = 40;
        fill_script(1);
        script[0] = 4'd3; script[1] = 4'd6; script[2] = 4'd0;
        good_image(1'b1);
        seen_cmds.delete();
        fin_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (seen_cmds.size() == 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_val("pre_reset_first_issue", seen_cmds.size(), 1);
        repeat (10) @(negedge clk);
        check_val("pre_reset_cmd_issued", 32'(cmd_issued), 1);
        check_val("pre_reset_host_busy", 32'(host_busy), 1);
        reset = 1'b0;
        busy  = 1'b0;
        @(negedge clk);
        check_reset_state();
        repeat (5) @(negedge clk);
        check_val("no_finish_in_reset", fin_cnt, 0);
        reset     = 1'b1;
        ack_delay = 3;
        repeat (2) @(negedge clk);
        run_and_check("after_reset", 6000);

        // Randomized scripts and write streams.
        for (int it = 0; it < 20; it++) begin
            settle();
            ack_delay = int'($urandom_range(2, 6));
            fill_script(0);
            sel = int'($urandom_range(0, 5));
            if (sel == 5) begin
                for (int i = 0; i < 64; i++)
                    if (script[i] == 4'd0) script[i] = 4'($urandom_range(1, 15));
            end else begin
                k = int'($urandom_range(0, 10));
                for (int i = 0; i < k; i++)
                    if (script[i] == 4'd0) script[i] = 4'($urandom_range(1, 15));
                script[k] = 4'd0;
            end
            good_image(1'b1);
            sel = int'($urandom_range(0, 3));
            if (sel == 1) n_writes = int'($urandom_range(0, 63));
            if (sel == 2) begin
                k = int'($urandom_range(0, 63));
                wr_addr[k] = 6'((k + int'($urandom_range(1, 63))) % 64);
            end
            if (sel == 3) done_with_last = 1'b1;
            run_and_check($sformatf("rand_%0d", it), 6000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
